button_conditioner: RTL and testbench

//  Front end for the menu controller. Conditions the five raw board push buttons into clean signals.

---
 rtl/button_conditioner_pkg.sv | 30 +++
 rtl/button_conditioner_if.sv | 27 ++
 rtl/button_conditioner_debounce_channel.sv | 157 +++++++++++++++
 rtl/button_conditioner.sv | 57 +++++
 tb/tb_button_conditioner.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared button bit map, debounce FSM state type and width helpers for the button conditioner.
package btn_pkg;

  localparam int N_BTN = 5;

  typedef enum logic [2:0] {
    BTN_UP     = 3'd0,
    BTN_DOWN   = 3'd1,
    BTN_LEFT   = 3'd2,
    BTN_RIGHT  = 3'd3,
    BTN_SELECT = 3'd4
  } btn_id_t;

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } deb_state_t;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw pads in, debounced level / press pulses out.
interface button_conditioner_if
  import btn_pkg::*;
#(
  parameter int N = N_BTN
);

  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;
  logic         any_pulse;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_pulse,
    input  any_pulse
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_pulse,
    output any_pulse
  );

endinterface

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM and, with BTN_AUTOREPEAT_EN defined,
// an optional hold-to-repeat pulse generator.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 15_000_000,
  parameter bit REPEAT_ALLOWED      = 1'b0
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_d_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             sync;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             press_fire;
  logic             rep_fire;

  assign sync = sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // The counter only runs while waiting; every state change restarts it from zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_fire = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          level_d    = 1'b1;
          press_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  generate
    if (REPEAT_ALLOWED) begin : g_rep
      localparam int RPT_W = cnt_width(max2(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
      localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
      localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

      logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
      logic             rpt_later_q, rpt_later_d;
      logic             rpt_fire;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rpt_cnt_q   <= '0;
          rpt_later_q <= 1'b0;
        end else begin
          rpt_cnt_q   <= rpt_cnt_d;
          rpt_later_q <= rpt_later_d;
        end
      end

      // First threshold is the initial hold delay, every later one is the repeat period.
      always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_later_d = rpt_later_q;
        rpt_fire    = 1'b0;
        if (state_q == STABLE_HI && sync) begin
          if (rpt_cnt_q == (rpt_later_q ? RATE_LAST : DELAY_LAST)) begin
            rpt_fire    = 1'b1;
            rpt_cnt_d   = '0;
            rpt_later_d = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end else begin
          rpt_cnt_d   = '0;
          rpt_later_d = 1'b0;
        end
      end

      assign rep_fire = rpt_fire;
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
  endgenerate
`else
  assign rep_fire = 1'b0;
`endif

  assign pulse_d   = press_fire | rep_fire;
  assign pulse_d_o = pulse_d;
  assign level_o   = level_q;
  assign pulse_o   = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-channel push-button front end: independent debounced levels and press pulses plus a
// registered OR of all pulses. Auto-repeat on channels 0..3 is built only with BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 15_000_000
`endif
) (
  input logic clk,
  input logic reset,
  button_conditioner_if.slave bus
);

  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] pulse_w;
  logic [N_BTN-1:0] pulse_d_w;
  logic             any_pulse_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      btn_debounce_channel #(
        .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
        .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
        .REPEAT_ALLOWED     (gi != int'(BTN_SELECT))
`endif
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (bus.btn_in[gi]),
        .level_o  (level_w[gi]),
        .pulse_o  (pulse_w[gi]),
        .pulse_d_o(pulse_d_w[gi])
      );
    end
  endgenerate

  // Built from the channels' next-state pulses so it lands in the same cycle as btn_pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      any_pulse_q <= 1'b0;
    end else begin
      any_pulse_q <= |pulse_d_w;
    end
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_w;
  assign bus.any_pulse = any_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Table-driven bench for button_conditioner with a per-cycle expected-output scoreboard.
module tb_button_conditioner;
  import btn_pkg::*;

  localparam int DEB = 8;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RDLY = 40;
  localparam int RRATE = 10;
  localparam logic [N_BTN-1:0] RPT_MASK = 5'b01111;
`endif

  typedef struct {
    string            name;
    logic [N_BTN-1:0] mask;
    int               hold;
    int               pulse_cyc;
    int               lvl_last;
  } vec_t;

  typedef struct {
    logic [N_BTN-1:0] pulse;
    logic [N_BTN-1:0] level;
    logic             any;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  button_conditioner_if #(.N(N_BTN)) bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_CYCLES(RDLY),
    .REPEAT_RATE_CYCLES (RRATE)
`endif
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;
  vec_t vecs[7];

  task automatic cmp(input string what, input int c, input logic [N_BTN-1:0] act,
                     input logic [N_BTN-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", what, c, act, req);
  endtask

  // Expected outputs for cycles 0..n-1 after a press edge at cycle 0.
  task automatic push_expected(input logic [N_BTN-1:0] mask, input int n, input int pcyc,
                               input int llast, input int rpt_limit);
    for (int c = 0; c < n; c++) begin
      exp_t e;
      e.pulse = (c == pcyc) ? mask : '0;
`ifdef BTN_AUTOREPEAT_EN
      if (pcyc >= 0)
        for (int r = pcyc + RDLY; r <= rpt_limit; r += RRATE)
          if (c == r) e.pulse = e.pulse | (mask & RPT_MASK);
`else
      if (rpt_limit < 0) e.pulse = '0;
`endif
      e.level = (pcyc >= 0 && c >= pcyc && c <= llast) ? mask : '0;
      e.any   = |e.pulse;
      sb.push_back(e);
    end
  endtask

  task automatic check_cycle(input string name, input int c);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s cycle %0d: scoreboard empty, got pulse %b", name, c, bus.btn_pulse);
      return;
    end
    e = sb.pop_front();
    cmp({name, " pulse"}, c, bus.btn_pulse, e.pulse);
    cmp({name, " level"}, c, bus.btn_level, e.level);
    cmp({name, " any"}, c, {4'b0000, bus.any_pulse}, {4'b0000, e.any});
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = v.hold + 25;
    push_expected(v.mask, n, v.pulse_cyc, v.lvl_last, v.hold + 2);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      check_cycle(v.name, c);
      bus.btn_in = (c < v.hold) ? v.mask : '0;
    end
    $display("vec %-16s mask=%b hold=%0d checked over %0d cycles", v.name, v.mask, v.hold, n);
  endtask

  initial begin
    vecs[0] = '{"up_30",          5'b00001, 30, 11, 40};
    vecs[1] = '{"down_select_20", 5'b10010, 20, 11, 30};
    vecs[2] = '{"left_8_short",   5'b00100,  8, -1, -1};
    vecs[3] = '{"left_9_min",     5'b00100,  9, 11, 19};
    vecs[4] = '{"all_12",         5'b11111, 12, 11, 22};
    vecs[5] = '{"right_3_glitch", 5'b01000,  3, -1, -1};
    vecs[6] = '{"left_select_90", 5'b10100, 90, 11, 100};

    // Reset held with every pad pressed: all outputs must stay low.
    reset = 1'b1;
    bus.btn_in = 5'b11111;
    push_expected('0, 4, -1, -1, 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_cycle("reset_hold", c);
    end
    $display("seq reset_hold checked over 4 cycles");
    bus.btn_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bounce: 3-cycle chatter, then a stable rise at cycle 21 held until cycle 49.
    push_expected(5'b00100, 80, 32, 60, 52);
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      check_cycle("bounce", c);
      bus.btn_in = ((c < 18 && (c / 3) % 2 == 0) || (c >= 21 && c < 50)) ? 5'b00100 : '0;
    end
    $display("seq bounce checked over 80 cycles");

    // Reset pulse mid-debounce: press restarts from reset release at cycle 6.
    push_expected(5'b01000, 50, 17, 35, 27);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      check_cycle("reset_mid", c);
      bus.btn_in = (c < 25) ? 5'b01000 : '0;
      if (c == 5) reset = 1'b1;
      if (c == 6) reset = 1'b0;
    end
    $display("seq reset_mid checked over 50 cycles");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
